// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier for two's-complement
// operands. Each clock performs one add/subtract-and-shift step, so one
// product completes every WIDTH iterations.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request, sampled when idle or in the done cycle
//   multiplicand signed operand M, sampled with start
//   multiplier   signed operand Q, sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse when product has just been updated
//   product      registered signed M*Q, held until the next completion
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  // Accumulator is one bit wider than the operands so that subtracting
  // M = -2^(WIDTH-1) cannot overflow.
  logic [WIDTH:0]   a_reg;
  logic [WIDTH:0]   mx_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_1;
  logic [CW-1:0]    count;

  logic load, step, finish;

  logic [WIDTH:0]   a_sel;
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Add/subtract stage built from a chain of full-adder cells. Subtraction
  // is ~Mx with the carry-in forced to 1.
  always_comb begin : addsub
    logic           sub;
    logic           c;
    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;
    sub    = q_reg[0] & ~q_1;
    addend = sub ? ~mx_reg : mx_reg;
    // NOTE: the carry is a blocking temporary so each bit sees the carry
    // produced by the previous bit within the same evaluation.
    c      = sub;
    sum    = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      sum[i] = a_reg[i] ^ addend[i] ^ c;
      c      = (a_reg[i] & addend[i]) | (c & (a_reg[i] ^ addend[i]));
    end
    // Booth pairs 00 and 11 leave the accumulator untouched.
    a_sel = (q_reg[0] ^ q_1) ? sum : a_reg;
  end

  // Arithmetic right shift of {A,Q,q_1}, replicating the sign of A.
  assign a_nxt = {a_sel[WIDTH], a_sel[WIDTH:1]};
  assign q_nxt = {a_sel[0], q_reg[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (count == LAST) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      mx_reg  <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else if (load) begin
      a_reg   <= '0;
      mx_reg  <= {multiplicand[WIDTH-1], multiplicand};
      q_reg   <= multiplier;
      q_1     <= 1'b0;
      count   <= '0;
    end else if (step) begin
      a_reg   <= a_nxt;
      q_reg   <= q_nxt;
      q_1     <= q_reg[0];
      count   <= count + CW'(1);
      // Product is taken from the post-shift value of the final iteration.
      if (finish) product <= {a_nxt[WIDTH-1:0], q_nxt};
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed vectors for booth_seq_mult (WIDTH=8). Expected
// products are pushed into a queue at issue time; a monitor pops and compares
// whenever done is seen.
module tb_booth_seq_mult;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp;

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(product), 32'hDEAD_BEEF);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("product", 32'(product), 32'(e));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // Present operands at a negedge, accept on the next posedge.
  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q,
                       input logic [2*W-1:0] exp, input bit push);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    if (push) begin
      exp_q.push_back(exp);
      last_exp = exp;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done, counting busy cycles seen beforehand.
  task automatic wait_done(output int busy_cycles);
    bit found;
    found       = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else if (busy) busy_cycles++;
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  int bc;

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    last_exp     = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic: busy for exactly W cycles, then done.
    issue(8'd3, 8'd5, 16'h000F, 1'b1);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_done(bc);
    check("busy_cycles", 32'(bc), 32'(W));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // Sign cases and extremes.
    issue(-8'sd7, 8'd6, 16'hFFD6, 1'b1);     wait_done(bc);
    issue(8'h80, 8'd127, 16'hC080, 1'b1);    wait_done(bc);
    issue(8'h80, 8'h80, 16'h4000, 1'b1);     wait_done(bc);
    issue(8'd127, 8'd127, 16'h3F01, 1'b1);   wait_done(bc);
    issue(8'd0, 8'hFF, 16'h0000, 1'b1);      wait_done(bc);
    issue(8'hFF, 8'hFF, 16'h0001, 1'b1);     wait_done(bc);
    repeat (5) @(negedge clk);
    check("product_hold_idle", 32'(product), 32'h0001);

    // Busy guard: a start during CALC is ignored.
    issue(8'd2, 8'd3, 16'h0006, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    @(posedge clk);
    #1 start = 1'b0;
    check("product_stable_calc", 32'(product), 32'h0001);
    wait_done(bc);
    repeat (15) @(negedge clk);
    check("no_second_op_busy", 32'(busy), 32'd0);

    // Back-to-back: start held high, new operands presented in done cycle.
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd5; multiplier = 8'd5;
    exp_q.push_back(16'h0019);
    wait_done(bc);
    multiplicand = 8'hFE; multiplier = 8'd4;
    exp_q.push_back(16'hFFF8);
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_reload_busy", 32'(busy), 32'd1);
    wait_done(bc);
    check("b2b_busy_cycles", 32'(bc), 32'(W));

    // Reset mid-operation, asserted between edges.
    issue(8'd7, 8'd7, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done), 32'd0);
    issue(8'd3, 8'hFD, 16'hFFF7, 1'b1);
    wait_done(bc);
    check("post_rst_busy_cycles", 32'(bc), 32'(W));

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
